// File: rtl/adder_mask.sv
// Groups macros by filter index and emits one adder-tree select mask per group leader.
// Latency 1 cycle (registered output); no backpressure, a new WHICH_FILTER is sampled every cycle.
module adder_mask #(
    parameter int NUM_MACRO  = 16,
    parameter int OUT_CH     = 512,
    localparam int BIT_OUT_CH = $clog2(OUT_CH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MACRO*BIT_OUT_CH-1:0]   WHICH_FILTER,
    output logic [NUM_MACRO*NUM_MACRO-1:0]    Adder_mask
);

    logic [NUM_MACRO*NUM_MACRO-1:0] same;
    logic [NUM_MACRO-1:0]           leader;
    logic [NUM_MACRO*NUM_MACRO-1:0] mask_d;
    logic [NUM_MACRO*NUM_MACRO-1:0] mask_q;

    // same[r*NUM_MACRO + j] is set when macros r and j target the same raw filter index
    always_comb begin
        same = '0;
        for (int r = 0; r < NUM_MACRO; r++) begin
            for (int j = 0; j < NUM_MACRO; j++) begin
                same[r*NUM_MACRO + j] =
                    (WHICH_FILTER[r*BIT_OUT_CH +: BIT_OUT_CH] == WHICH_FILTER[j*BIT_OUT_CH +: BIT_OUT_CH]);
            end
        end
    end

    // The lowest-numbered macro of each group owns that group's adder
    always_comb begin
        leader = '1;
        for (int r = 0; r < NUM_MACRO; r++) begin
            for (int k = 0; k < NUM_MACRO; k++) begin
                if (k < r && same[r*NUM_MACRO + k]) begin
                    leader[r] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        mask_d = '0;
        for (int r = 0; r < NUM_MACRO; r++) begin
            if (leader[r]) begin
                mask_d[r*NUM_MACRO +: NUM_MACRO] = same[r*NUM_MACRO +: NUM_MACRO];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign Adder_mask = mask_q;

endmodule

// File: tb/tb_adder_mask.sv
// Randomized and directed bench for adder_mask against a first-occurrence grouping model.
module tb_adder_mask;

    localparam int N  = 16;
    localparam int B  = 9;
    localparam int WW = N*B;
    localparam int MW = N*N;

    logic          clk;
    logic          rst_n;
    logic [WW-1:0] which_filter;
    logic [MW-1:0] adder_mask;

    int n_checks;
    int n_errors;

    adder_mask #(.NUM_MACRO(N), .OUT_CH(512)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .WHICH_FILTER (which_filter),
        .Adder_mask   (adder_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Each macro is added into the row of the first macro carrying the same filter value
    function automatic logic [MW-1:0] ref_mask(input logic [WW-1:0] wf);
        logic [MW-1:0] m;
        int owner;
        m = '0;
        for (int j = 0; j < N; j++) begin
            owner = j;
            for (int k = N-1; k >= 0; k--) begin
                if (k <= j && wf[k*B +: B] == wf[j*B +: B]) owner = k;
            end
            m[owner*N + j] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [15:0] row(input logic [MW-1:0] m, input int r);
        return m[r*N +: N];
    endfunction

    task automatic check_partition(input string tag, input logic [MW-1:0] m);
        logic [15:0] uni;
        logic [15:0] ovl;
        uni = '0;
        ovl = '0;
        for (int r = 0; r < N; r++) begin
            ovl = ovl | (uni & row(m, r));
            uni = uni | row(m, r);
        end
        check({tag, "_disjoint"}, MW'(ovl), '0);
        check({tag, "_union"}, MW'(uni), MW'(16'hFFFF));
    endtask

    task automatic apply(input logic [WW-1:0] wf);
        which_filter = wf;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] rand_wf(input int maxv);
        logic [WW-1:0] wf;
        for (int m = 0; m < N; m++) wf[m*B +: B] = B'($urandom_range(maxv, 0));
        return wf;
    endfunction

    initial begin
        logic [WW-1:0] wf;
        logic [MW-1:0] exp_m;
        logic [MW-1:0] prev_m;
        n_checks = 0;
        n_errors = 0;

        // Reset holds the output at zero regardless of input
        rst_n = 1'b0;
        which_filter = rand_wf(511);
        for (int c = 0; c < 2; c++) begin
            apply(rand_wf(511));
            check("reset", adder_mask, '0);
        end
        rst_n = 1'b1;

        // All macros on one filter
        for (int m = 0; m < N; m++) wf[m*B +: B] = 9'd5;
        apply(wf);
        check("all_equal", adder_mask, ref_mask(wf));
        check("all_equal_row0", MW'(row(adder_mask, 0)), MW'(16'hFFFF));
        check("all_equal_row1", MW'(row(adder_mask, 1)), '0);

        // Output must not move before the next edge
        for (int m = 0; m < N; m++) wf[m*B +: B] = B'(m);
        which_filter = wf;
        #2;
        check("latency_hold", adder_mask, ref_mask({N{9'd5}}));
        @(posedge clk);
        #1;
        check("all_distinct", adder_mask, ref_mask(wf));
        for (int r = 0; r < N; r++) begin
            if (row(adder_mask, r) !== (16'h1 << r)) begin
                check($sformatf("identity_row%0d", r), MW'(row(adder_mask, r)), MW'(16'h1 << r));
            end
        end
        check("identity_pattern", adder_mask, {16'h8000, 16'h4000, 16'h2000, 16'h1000,
                                               16'h0800, 16'h0400, 16'h0200, 16'h0100,
                                               16'h0080, 16'h0040, 16'h0020, 16'h0010,
                                               16'h0008, 16'h0004, 16'h0002, 16'h0001});

        // Even/odd groups
        for (int m = 0; m < N; m++) wf[m*B +: B] = (m % 2 == 0) ? 9'd3 : 9'd7;
        apply(wf);
        check("two_groups", adder_mask, ref_mask(wf));
        check("two_groups_row0", MW'(row(adder_mask, 0)), MW'(16'h5555));
        check("two_groups_row1", MW'(row(adder_mask, 1)), MW'(16'hAAAA));

        // Mixed: a 511 group, a 0 group and singletons
        for (int m = 0; m < N; m++) begin
            if (m == 0 || m == 4 || m == 15) wf[m*B +: B] = 9'd511;
            else if (m == 2 || m == 3)       wf[m*B +: B] = 9'd0;
            else                             wf[m*B +: B] = B'(m);
        end
        apply(wf);
        check("mixed", adder_mask, ref_mask(wf));
        check("mixed_row0", MW'(row(adder_mask, 0)), MW'(16'h8011));
        check("mixed_row2", MW'(row(adder_mask, 2)), MW'(16'h000C));
        check("mixed_row1", MW'(row(adder_mask, 1)), MW'(16'h0002));
        check("mixed_row3", MW'(row(adder_mask, 3)), '0);
        check("mixed_row4", MW'(row(adder_mask, 4)), '0);
        check("mixed_row15", MW'(row(adder_mask, 15)), '0);
        check_partition("mixed", adder_mask);

        // Reset mid-stream overrides a live input
        rst_n = 1'b0;
        apply(rand_wf(3));
        check("reset_mid", adder_mask, '0);
        rst_n = 1'b1;
        wf = rand_wf(3);
        apply(wf);
        check("post_reset_first", adder_mask, ref_mask(wf));

        // Random grouping with a small value range to force many collisions
        prev_m = ref_mask(wf);
        for (int i = 0; i < 10000; i++) begin
            wf = rand_wf(3);
            which_filter = wf;
            exp_m = ref_mask(wf);
            #1;
            check("rand_hold", adder_mask, prev_m);
            @(posedge clk);
            #1;
            check("rand", adder_mask, exp_m);
            check_partition("rand", adder_mask);
            prev_m = exp_m;
        end

        // Wide-range random values
        for (int i = 0; i < 200; i++) begin
            wf = rand_wf(511);
            apply(wf);
            check("rand_wide", adder_mask, ref_mask(wf));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_mask.md
ADDER_MASK -- requirements
Module: adder_mask

Interface
REQ-001 The block SHALL have parameter NUM_MACRO, default 16: number of compute macros, each producing one partial sum.
REQ-002 The block SHALL have parameter OUT_CH, default 512: number of output channels (filters).
REQ-003 The block SHALL derive localparam BIT_OUT_CH = clog2(OUT_CH), default 9: width of one filter index.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port WHICH_FILTER, input, NUM_MACRO*BIT_OUT_CH bits: filter index per macro; macro m's field occupies bits [m*BIT_OUT_CH +: BIT_OUT_CH].
REQ-007 The block SHALL have port Adder_mask, output, NUM_MACRO*NUM_MACRO bits: adder-tree select masks; row r occupies bits [r*NUM_MACRO +: NUM_MACRO], and bit j of row r selects macro j.

Function
REQ-008 The block SHALL treat each row r as the input-select mask of adder r, which sums the partial sums of all macros sharing a filter.
REQ-009 Macro r SHALL be a group leader iff no macro k < r has WHICH_FILTER[k] == WHICH_FILTER[r].
REQ-010 For a leader r, row r bit j SHALL be 1 iff WHICH_FILTER[j] == WHICH_FILTER[r] (full BIT_OUT_CH-bit equality); bit r is therefore always 1.
REQ-011 For a non-leader r, row r SHALL be all zeros.
REQ-012 Each macro SHALL appear in exactly one non-zero row; the OR of all rows SHALL be all ones, and rows SHALL be pairwise disjoint.
REQ-013 The mask SHALL be computed combinationally from the current WHICH_FILTER and registered; Adder_mask SHALL be the registered value, with latency exactly 1 clk cycle.
REQ-014 The block SHALL sample a new WHICH_FILTER every cycle with no handshake; the output SHALL track input changes one cycle later.
REQ-015 Filter index values SHALL be compared as raw bits; values >= OUT_CH (when OUT_CH is not a power of two) SHALL need no range check and are grouped like any other value.
REQ-016 Boundary: if all macros share one filter, row 0 SHALL be all ones and all other rows zero.
REQ-017 Boundary: if all filters are distinct, row r SHALL equal one-hot (1<<r), forming an identity pattern.

Reset
REQ-018 When rst_n == 0 at a rising clk edge, the Adder_mask register SHALL load all zeros.
REQ-019 An asserted reset SHALL override any input; after rst_n returns to 1, the first valid mask SHALL appear one cycle after the first sampled edge.
REQ-020 The block SHALL have no state other than the output register.

Verification
REQ-021 Reset: rst_n=0 for 2 cycles with random WHICH_FILTER -> Adder_mask == 0 throughout.
REQ-022 All equal: every field = 5 -> next cycle row0 = 0xFFFF, rows 1..15 = 0.
REQ-023 All distinct: field m = m -> next cycle row r = 16'h1<<r for every r.
REQ-024 Two groups: even macros = 3, odd macros = 7 -> row0 = 0x5555, row1 = 0xAAAA, others 0.
REQ-025 Mixed: macros 0,4,15 = 511; macros 2,3 = 0; the rest distinct unique values -> row0 = 0x8011, row2 = 0x000C, each remaining unique macro's row = its own one-hot bit, rows 3, 4 and 15 = 0.
REQ-026 Random: 10k random vectors with a restricted value range of 0..3 -> each output equals the reference grouping of the previous-cycle input, and rows are disjoint with a union of 0xFFFF.
